// File: rtl/ram_uart_pkg.sv
// Shared constants, state encoding and request payload for the RAM/UART bridge.
package ram_uart_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BYTE_W-1:0] CMD_WRITE_DEF = 8'h57;  // 'W'
    localparam logic [BYTE_W-1:0] CMD_READ_DEF  = 8'h52;  // 'R'

    typedef enum logic [3:0] {
        IDLE,
        ADDR2,
        ADDR1,
        ADDR0,
        DATA1,
        DATA0,
        MEM_REQ,
        MEM_WAIT,
        TX1,
        TX1_WAIT,
        TX0,
        TX0_WAIT
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ram_uart_bridge_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus rising-edge detect.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise_c
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw level in; [1] is the synchronized level, [2] its last value.
    always_comb begin
        sync_d = {sync_q[1:0], d_in};
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ram_uart_bridge.sv
// Byte-framed UART command bridge to a single-word RAM controller.
module ram_uart_bridge
    import ram_uart_pkg::*;
#(
    parameter int unsigned       DONE_TIMEOUT = 1024,
    parameter logic [BYTE_W-1:0] CMD_WRITE    = CMD_WRITE_DEF,
    parameter logic [BYTE_W-1:0] CMD_READ     = CMD_READ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_en,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              seen_q, seen_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_rise_c;

    sync_edge u_done_sync (
        .clk    (clk),
        .rst_n  (rst),
        .d_in   (mem_done),
        .rise_c (done_rise_c)
    );

    // Next-state and registered-output logic; outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        err_d      = err_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
                    is_wr_d = (rx_data == CMD_WRITE);
                    state_d = ADDR2;
                end
            end
            ADDR2: begin
                if (rx_valid) begin
                    req_d.addr[17:16] = rx_data[1:0];
                    state_d           = ADDR1;
                end
            end
            ADDR1: begin
                if (rx_valid) begin
                    req_d.addr[15:8] = rx_data;
                    state_d          = ADDR0;
                end
            end
            ADDR0: begin
                if (rx_valid) begin
                    req_d.addr[7:0] = rx_data;
                    state_d         = is_wr_q ? DATA1 : MEM_REQ;
                end
            end
            DATA1: begin
                if (rx_valid) begin
                    req_d.wdata[15:8] = rx_data;
                    state_d           = DATA0;
                end
            end
            DATA0: begin
                if (rx_valid) begin
                    req_d.wdata[7:0] = rx_data;
                    state_d          = MEM_REQ;
                end
            end
            MEM_REQ: begin
                cnt_d   = '0;
                state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                // A done edge wins over a timeout landing in the same cycle.
                cnt_d = cnt_q + CNT_W'(1);
                if (done_rise_c) begin
                    if (is_wr_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = mem_rdata;
                        state_d = TX1;
                    end
                end else if (cnt_d == CNT_W'(DONE_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            TX1: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rdata_q[15:8];
                    seen_d     = 1'b0;
                    state_d    = TX1_WAIT;
                end
            end
            TX1_WAIT: begin
                if (!seen_q) begin
                    if (tx_busy) seen_d = 1'b1;
                end else if (!tx_busy) begin
                    state_d = TX0;
                end
            end
            TX0: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rdata_q[7:0];
                    seen_d     = 1'b0;
                    state_d    = TX0_WAIT;
                end
            end
            TX0_WAIT: begin
                if (!seen_q) begin
                    if (tx_busy) seen_d = 1'b1;
                end else if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_en_d = (state_d == MEM_REQ) || (state_d == MEM_WAIT);
        mem_we_d = mem_en_d && is_wr_d;
        mem_re_d = mem_en_d && !is_wr_d;
        busy_d   = (state_d != IDLE);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            req_q      <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign mem_en    = mem_en_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
